// File: rtl/hand_tracker.sv
// Smooths camera hand-centroid samples into a sprite position, once per frame,
// and debounces the open/closed grip into OPEN/HOLD/LOST.
module hand_tracker #(
  parameter int SCREEN_W    = 1024,
  parameter int SCREEN_H    = 768,
  parameter int SPRITE_W    = 64,
  parameter int SPRITE_H    = 64,
  parameter int GRIP_FRAMES = 3,
  parameter int LOST_FRAMES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic [10:0] raw_x,
  input  logic [9:0]  raw_y,
  input  logic        raw_valid,
  input  logic        grip,
  output logic [15:0] x,
  output logic [15:0] y,
  output logic [1:0]  ball_state,
  output logic        update
);

  localparam logic [1:0] ST_OPEN = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_LOST = 2'd2;

  localparam int          GW         = (GRIP_FRAMES < 2) ? 1 : $clog2(GRIP_FRAMES + 1);
  localparam logic [10:0] MAX_X      = 11'(SCREEN_W - SPRITE_W);
  localparam logic [9:0]  MAX_Y      = 10'(SCREEN_H - SPRITE_H);
  localparam logic [10:0] HOME_X     = 11'((SCREEN_W - SPRITE_W) / 2);
  localparam logic [9:0]  HOME_Y     = 10'((SCREEN_H - SPRITE_H) / 2);
  localparam logic [GW-1:0] GRIP_LIMIT = GW'(GRIP_FRAMES);
  localparam logic [3:0]  LOST_LIMIT = 4'(LOST_FRAMES);

  logic [10:0]   pend_x_reg, pend_x_next;
  logic [9:0]    pend_y_reg, pend_y_next;
  logic          pend_grip_reg, pend_grip_next;
  logic          pending_reg, pending_next;
  logic [10:0]   x_reg, x_next;
  logic [9:0]    y_reg, y_next;
  logic [1:0]    state_reg, state_next;
  logic [3:0]    miss_reg, miss_next;
  logic [GW-1:0] open_cnt_reg, open_cnt_next;
  logic [GW-1:0] hold_cnt_reg, hold_cnt_next;
  logic          update_reg;

  logic [10:0]   tgt_x;
  logic [9:0]    tgt_y;
  logic [10:0]   step_y_wide;
  logic [3:0]    miss_inc;
  logic [GW-1:0] open_inc, hold_inc;

  // Moves a quarter of the way toward the target, snapping when within 3 pixels.
  // The floor-shift guarantees the result never overshoots, so it stays in range.
  function automatic logic [10:0] approach(input logic [10:0] cur, input logic [10:0] tgt);
    logic signed [16:0] diff;
    logic signed [16:0] step;
    logic signed [16:0] sum;
    diff = $signed({6'b0, tgt}) - $signed({6'b0, cur});
    step = diff >>> 2;
    sum  = $signed({6'b0, cur}) + step;
    if (diff >= -17'sd3 && diff <= 17'sd3)
      return tgt;
    return sum[10:0];
  endfunction

  assign tgt_x       = (pend_x_reg > MAX_X) ? MAX_X : pend_x_reg;
  assign tgt_y       = (pend_y_reg > MAX_Y) ? MAX_Y : pend_y_reg;
  assign step_y_wide = approach({1'b0, y_reg}, {1'b0, tgt_y});
  assign miss_inc    = (miss_reg == 4'd15) ? 4'd15 : miss_reg + 4'd1;
  assign open_inc    = open_cnt_reg + 1'b1;
  assign hold_inc    = hold_cnt_reg + 1'b1;

  always_comb begin
    pend_x_next    = pend_x_reg;
    pend_y_next    = pend_y_reg;
    pend_grip_next = pend_grip_reg;
    pending_next   = pending_reg;
    x_next         = x_reg;
    y_next         = y_reg;
    state_next     = state_reg;
    miss_next      = miss_reg;
    open_cnt_next  = open_cnt_reg;
    hold_cnt_next  = hold_cnt_reg;

    // A sample arriving with the tick is kept for the next frame.
    if (raw_valid) begin
      pend_x_next    = raw_x;
      pend_y_next    = raw_y;
      pend_grip_next = grip;
      pending_next   = 1'b1;
    end else if (frame_tick) begin
      pending_next = 1'b0;
    end

    if (frame_tick) begin
      if (pending_reg) begin
        miss_next = 4'd0;
        if (state_reg == ST_LOST) begin
          x_next        = tgt_x;
          y_next        = tgt_y;
          state_next    = ST_OPEN;
          open_cnt_next = '0;
          hold_cnt_next = '0;
        end else begin
          x_next = approach(x_reg, tgt_x);
          y_next = step_y_wide[9:0];
          if (state_reg == ST_OPEN) begin
            if (!pend_grip_reg) begin
              open_cnt_next = '0;
            end else if (open_inc >= GRIP_LIMIT) begin
              state_next    = ST_HOLD;
              open_cnt_next = '0;
              hold_cnt_next = '0;
            end else begin
              open_cnt_next = open_inc;
            end
          end else begin
            if (pend_grip_reg) begin
              hold_cnt_next = '0;
            end else if (hold_inc >= GRIP_LIMIT) begin
              state_next    = ST_OPEN;
              open_cnt_next = '0;
              hold_cnt_next = '0;
            end else begin
              hold_cnt_next = hold_inc;
            end
          end
        end
      end else begin
        miss_next = miss_inc;
        if (miss_inc == LOST_LIMIT) begin
          state_next    = ST_LOST;
          open_cnt_next = '0;
          hold_cnt_next = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_x_reg    <= '0;
      pend_y_reg    <= '0;
      pend_grip_reg <= 1'b0;
      pending_reg   <= 1'b0;
      x_reg         <= HOME_X;
      y_reg         <= HOME_Y;
      state_reg     <= ST_LOST;
      miss_reg      <= 4'd0;
      open_cnt_reg  <= '0;
      hold_cnt_reg  <= '0;
      update_reg    <= 1'b0;
    end else begin
      pend_x_reg    <= pend_x_next;
      pend_y_reg    <= pend_y_next;
      pend_grip_reg <= pend_grip_next;
      pending_reg   <= pending_next;
      x_reg         <= x_next;
      y_reg         <= y_next;
      state_reg     <= state_next;
      miss_reg      <= miss_next;
      open_cnt_reg  <= open_cnt_next;
      hold_cnt_reg  <= hold_cnt_next;
      update_reg    <= frame_tick;
    end
  end

  assign x          = {5'b0, x_reg};
  assign y          = {6'b0, y_reg};
  assign ball_state = state_reg;
  assign update     = update_reg;

endmodule

// File: tb/tb_hand_tracker.sv
// Directed bench for hand_tracker: a table of per-frame samples with expected
// outputs, followed by hand-written coincident-strobe and reset sequences.
module tb_hand_tracker;

  logic        clk;
  logic        reset;
  logic        frame_tick;
  logic [10:0] raw_x;
  logic [9:0]  raw_y;
  logic        raw_valid;
  logic        grip;
  logic [15:0] x;
  logic [15:0] y;
  logic [1:0]  ball_state;
  logic        update;

  hand_tracker dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .raw_x      (raw_x),
    .raw_y      (raw_y),
    .raw_valid  (raw_valid),
    .grip       (grip),
    .x          (x),
    .y          (y),
    .ball_state (ball_state),
    .update     (update)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [10:0] rx;
    logic [9:0]  ry;
    logic        g;
    logic [15:0] ex;
    logic [15:0] ey;
    logic [1:0]  es;
  } vec_t;

  vec_t vec_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add_vec(input logic v, input logic [10:0] rx, input logic [9:0] ry,
                         input logic g, input logic [15:0] ex, input logic [15:0] ey,
                         input logic [1:0] es);
    vec_t r;
    r.valid = v; r.rx = rx; r.ry = ry; r.g = g; r.ex = ex; r.ey = ey; r.es = es;
    vec_q.push_back(r);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Optional sample strobe, then a frame tick; returns on the negedge where update is high.
  task automatic run_frame(input logic v, input logic [10:0] rx, input logic [9:0] ry,
                           input logic g);
    @(negedge clk);
    if (v) begin
      raw_valid = 1'b1; raw_x = rx; raw_y = ry; grip = g;
    end
    @(negedge clk);
    raw_valid  = 1'b0;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [15:0] ex, input logic [15:0] ey,
                           input logic [1:0] es);
    check({tag, " x"}, 32'(x), 32'(ex));
    check({tag, " y"}, 32'(y), 32'(ey));
    check({tag, " state"}, 32'(ball_state), 32'(es));
    check({tag, " update"}, 32'(update), 32'd1);
    $display("%s: x=%0d y=%0d state=%0d update=%0b", tag, x, y, ball_state, update);
  endtask

  initial begin
    reset = 1'b0; frame_tick = 1'b0; raw_valid = 1'b0;
    raw_x = '0; raw_y = '0; grip = 1'b0;

    // Tracking from LOST, small/large steps and the +-3 snap boundary.
    add_vec(1, 100, 200, 0, 100, 200, 0);
    add_vec(1,  95, 200, 0,  98, 200, 0);
    add_vec(1, 100, 200, 0, 100, 200, 0);
    add_vec(1, 300, 600, 0, 150, 300, 0);
    add_vec(1, 300, 600, 0, 187, 375, 0);
    add_vec(1, 190, 375, 0, 190, 375, 0);
    add_vec(1, 194, 375, 0, 191, 375, 0);
    add_vec(1, 187, 375, 0, 190, 375, 0);
    // Grip debounce into HOLD and back.
    add_vec(1, 190, 375, 1, 190, 375, 0);
    add_vec(1, 190, 375, 1, 190, 375, 0);
    add_vec(1, 190, 375, 1, 190, 375, 1);
    add_vec(1, 190, 375, 0, 190, 375, 1);
    add_vec(1, 190, 375, 0, 190, 375, 1);
    add_vec(1, 190, 375, 0, 190, 375, 0);
    // Eight empty frames lose the hand.
    for (int i = 0; i < 7; i++) add_vec(0, 0, 0, 0, 190, 375, 0);
    add_vec(0, 0, 0, 0, 190, 375, 2);
    // Clamping on reload and while tracking.
    add_vec(1, 1020, 760, 0, 960, 704, 0);
    add_vec(1, 2047, 1023, 0, 960, 704, 0);
    // An interrupted grip run restarts the count.
    add_vec(1, 960, 704, 1, 960, 704, 0);
    add_vec(1, 960, 704, 1, 960, 704, 0);
    add_vec(1, 960, 704, 0, 960, 704, 0);
    add_vec(1, 960, 704, 1, 960, 704, 0);
    add_vec(1, 960, 704, 1, 960, 704, 0);
    add_vec(1, 960, 704, 1, 960, 704, 1);
    // A sample frame clears the miss count.
    for (int i = 0; i < 7; i++) add_vec(0, 0, 0, 0, 960, 704, 1);
    add_vec(1, 960, 704, 1, 960, 704, 1);
    for (int i = 0; i < 7; i++) add_vec(0, 0, 0, 0, 960, 704, 1);
    add_vec(0, 0, 0, 0, 960, 704, 2);

    // Reset values appear without a clock edge.
    #1 reset = 1'b1;
    #1;
    check("por x", 32'(x), 32'd480);
    check("por y", 32'(y), 32'd352);
    check("por state", 32'(ball_state), 32'd2);
    check("por update", 32'(update), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    foreach (vec_q[i]) begin
      run_frame(vec_q[i].valid, vec_q[i].rx, vec_q[i].ry, vec_q[i].g);
      check_out($sformatf("frame %0d", i), vec_q[i].ex, vec_q[i].ey, vec_q[i].es);
      @(negedge clk);
      check($sformatf("frame %0d update low", i), 32'(update), 32'd0);
      check($sformatf("frame %0d x held", i), 32'(x), 32'(vec_q[i].ex));
    end

    // Coincident sample and tick from LOST: frame sees nothing, sample used next frame.
    @(negedge clk);
    raw_valid = 1'b1; raw_x = 50; raw_y = 60; grip = 1'b0; frame_tick = 1'b1;
    @(negedge clk);
    raw_valid = 1'b0; frame_tick = 1'b0;
    check_out("coincident lost", 960, 704, 2);
    run_frame(0, 0, 0, 0);
    check_out("coincident reload", 50, 60, 0);

    // Coincident while tracking: the older pending sample drives this frame.
    @(negedge clk);
    raw_valid = 1'b1; raw_x = 52; raw_y = 60; grip = 1'b0;
    @(negedge clk);
    raw_x = 400; frame_tick = 1'b1;
    @(negedge clk);
    raw_valid = 1'b0; frame_tick = 1'b0;
    check_out("coincident old sample", 52, 60, 0);
    run_frame(0, 0, 0, 0);
    check_out("coincident new sample", 139, 60, 0);

    // Mid-operation reset, with strobes ignored while it is held.
    run_frame(1, 700, 500, 0);
    reset = 1'b1;
    #1;
    check("mid reset x", 32'(x), 32'd480);
    check("mid reset y", 32'(y), 32'd352);
    check("mid reset state", 32'(ball_state), 32'd2);
    check("mid reset update", 32'(update), 32'd0);
    @(negedge clk);
    raw_valid = 1'b1; raw_x = 5; raw_y = 5; frame_tick = 1'b1;
    @(negedge clk);
    raw_valid = 1'b0; frame_tick = 1'b0;
    check("in reset update", 32'(update), 32'd0);
    check("in reset x", 32'(x), 32'd480);
    @(negedge clk);
    reset = 1'b0;
    run_frame(0, 0, 0, 0);
    check_out("after reset", 480, 352, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hand_tracker.md
HAND_TRACKER -- requirements
Module: hand_tracker

Interface
REQ-001 SHALL have parameter SCREEN_W, default 1024, meaning visible width in pixels.
REQ-002 SHALL have parameter SCREEN_H, default 768, meaning visible height in pixels.
REQ-003 SHALL have parameter SPRITE_W/SPRITE_H, default 64/64, meaning hand sprite size.
REQ-004 SHALL have parameter GRIP_FRAMES, default 3, meaning consecutive frames needed to change grip state.
REQ-005 SHALL have parameter LOST_FRAMES, default 8, meaning consecutive sample-less frames before LOST.
REQ-006 SHALL have port clk, input, 1, meaning the single system clock, with all logic in this domain.
REQ-007 SHALL have port reset, input, 1, meaning asynchronous, active-high reset.
REQ-008 SHALL have port frame_tick, input, 1, meaning a one-cycle pulse at the start of vertical blanking.
REQ-009 SHALL have port raw_x, input, 11, meaning the camera centroid x in screen pixels.
REQ-010 SHALL have port raw_y, input, 10, meaning the camera centroid y in screen pixels.
REQ-011 SHALL have port raw_valid, input, 1, meaning a one-cycle strobe qualifying raw_x/raw_y/grip.
REQ-012 SHALL have port grip, input, 1, meaning closed-hand detected for this sample.
REQ-013 SHALL have ports x and y, output, 16 each, meaning the sprite top-left position fed to the sprite draw stage.
REQ-014 SHALL have port ball_state, output, 2, meaning 0=OPEN, 1=HOLD, 2=LOST (3 never driven).
REQ-015 SHALL have port update, output, 1, meaning a one-cycle pulse marking that x/y/ball_state were refreshed.

Function
REQ-016 SHALL latch raw_x, raw_y and grip into pending registers and set pending on raw_valid; a later raw_valid overwrites the earlier sample.
REQ-017 SHALL clamp the pending target to x in [0, SCREEN_W-SPRITE_W] and y in [0, SCREEN_H-SPRITE_H], i.e. 960 and 704 at defaults.
REQ-018 SHALL, on frame_tick with pending=1 and state not LOST, compute diff=target-current as 17-bit signed.
REQ-019 SHALL, in that case, set new=target if -3<=diff<=3, else new=current+(diff>>>2) using an arithmetic shift that floors toward minus infinity.
REQ-020 SHALL, on frame_tick with pending=1 and state LOST, load the clamped target directly, enter OPEN, and clear both grip counters.
REQ-021 SHALL, on frame_tick with pending=0, hold x/y, hold the grip counters, and increment the miss counter, saturating at 15.
REQ-022 SHALL clear the miss counter on any frame_tick with pending=1.
REQ-023 SHALL enter LOST from any state on the frame_tick where the miss counter reaches LOST_FRAMES, clear the grip counters, and hold x/y.
REQ-024 SHALL count, in OPEN, consecutive pending frames with grip=1, resetting on a grip=0 frame, and enter HOLD when the count reaches GRIP_FRAMES.
REQ-025 SHALL count, in HOLD, consecutive pending frames with grip=0, resetting on a grip=1 frame, and enter OPEN when the count reaches GRIP_FRAMES.
REQ-026 SHALL clear pending on every frame_tick.
REQ-027 SHALL, when raw_valid and frame_tick coincide, process the frame with the pending contents from before that cycle, store the new sample, and leave pending=1 afterwards.
REQ-028 SHALL present x/y/ball_state one cycle after frame_tick, with update=1 for exactly that cycle (latency 1).
REQ-029 SHALL hold outputs stable between updates.
REQ-030 SHALL zero-extend x/y to 16 bits with bits [15:11] of x and [15:10] of y always 0.

Reset
REQ-031 SHALL, on reset assertion at any time including mid-frame, immediately set x=480, y=352, ball_state=2 (LOST), update=0, pending=0, miss counter=0 and grip counters=0.
REQ-032 SHALL ignore frame_tick and raw_valid while reset is high.

Verification
REQ-033 SHALL cover: assert reset mid-operation -> x=480, y=352, ball_state=2, update=0 without a clock edge.
REQ-034 SHALL cover: from LOST, raw_valid(100,200,grip=0) then frame_tick -> next cycle x=100, y=200, ball_state=0, update=1 for one cycle.
REQ-035 SHALL cover: at x=100, sample x=300 then frame_tick -> x=150; repeat -> x=187; at x=100, sample x=95 -> diff=-5 -> x=98.
REQ-036 SHALL cover: raw_x=1020, raw_y=760 from LOST -> x=960, y=704.
REQ-037 SHALL cover: in OPEN, three frames of samples with grip=1 -> ball_state=1 after the third; then two grip=0 frames -> still 1; a third -> 0.
REQ-038 SHALL cover: eight frame_ticks without raw_valid from OPEN -> ball_state=2 after the eighth with x/y unchanged; plus raw_valid coincident with frame_tick -> sample used on the following frame.
